// File: rtl/ysyx_23060042_lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_e : access FSM states
//   LSU_*       : funct3 access-type encodings
//   lsu_off_t   : byte-lane offset inside a 32-bit word
//   lsu_ctl_t   : control fields latched when an access is accepted
package ysyx_23060042_lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam int LSU_OFF_W = 2;
  typedef logic [LSU_OFF_W-1:0] lsu_off_t;

  typedef struct packed {
    logic       we;
    logic [2:0] op;
    lsu_off_t   off;
  } lsu_ctl_t;

endpackage

// File: rtl/ysyx_23060042_lsu_if.sv
// Core-side (EXU in / WBU out) and memory-bus signals of the LSU.
//   slave  : the LSU view (consumes in_*, out_ready, mem_gnt/rvalid/rdata)
//   master : the surroundings (EXU, WBU and memory model)
interface ysyx_23060042_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [2:0]        in_op;
  logic              in_ren;
  logic              in_wen;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic              out_err;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_op, in_ren, in_wen, out_ready,
           mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, out_valid, out_rdata, out_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_op, in_ren, in_wen, out_ready,
           mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, out_valid, out_rdata, out_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/ysyx_23060042_lsu_align.sv
// Byte-lane steering for the LSU (purely combinational).
//   op_i/off_i : access type and addr[1:0]
//   wdata_i    : store data -> wdata_o (lane replicated), wstrb_o
//   rdata_i    : bus read word -> rdata_o (shifted, sign/zero extended)
//   misalign_o : access crosses its natural alignment
// Build option: LSU_MISALIGN_CHK_EN enables misalign_o; otherwise it is 0
// and halfword/word offsets are forced to their aligned lane.
module ysyx_23060042_lsu_align
  import ysyx_23060042_lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  lsu_off_t    off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);
  logic        is_b, is_h, sgn;
  lsu_off_t    off;
  logic [31:0] sh;

  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    sgn  = 1'b0;
    case (op_i)
      LSU_B:   begin is_b = 1'b1; sgn = 1'b1; end
      LSU_BU:  is_b = 1'b1;
      LSU_H:   begin is_h = 1'b1; sgn = 1'b1; end
      LSU_HU:  is_h = 1'b1;
      LSU_W:   ;
      default: ; // undefined encodings behave as a word access
    endcase
  end

  // Halfwords keep only the upper offset bit, words always use lane 0.
  assign off     = is_b ? off_i : (is_h ? {off_i[1], 1'b0} : '0);
  assign wstrb_o = is_b ? (4'b0001 << off) : (is_h ? (4'b0011 << off) : 4'b1111);
  assign wdata_o = is_b ? {4{wdata_i[7:0]}} : (is_h ? {2{wdata_i[15:0]}} : wdata_i);
  assign sh      = rdata_i >> {off, 3'b000};
  assign rdata_o = is_b ? {{24{sgn & sh[7]}}, sh[7:0]} :
                   is_h ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign_o = (is_h & off_i[0]) | (~is_b & ~is_h & (off_i != 2'b00));
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/ysyx_23060042_lsu.sv
// Load/store unit: accepts one access from EXU, runs it on a req/gnt/rvalid
// bus and returns extended load data (or 0 / error) to WBU.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ysyx_23060042_lsu_if.slave (core handshake + memory bus)
// Parameters: ADDR_W, DATA_W (32), TIMEOUT_CYC (>=2, REQ+RESP cycle limit).
// Build option: LSU_MISALIGN_CHK_EN rejects misaligned H/W accesses with
// out_err and no bus traffic (handled inside the align sub-module).
module ysyx_23060042_lsu
  import ysyx_23060042_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
)(
  input  logic               clk,
  input  logic               rst_n,
  ysyx_23060042_lsu_if.slave bus
);
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q;
  lsu_ctl_t          ctl_q;
  logic [ADDR_W-3:0] waddr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [3:0]        wstrb_q;
  logic              in_ready_q, out_valid_q, err_q, req_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        al_op;
  lsu_off_t          al_off;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_wdata, al_rdata;
  logic              al_mis, is_mem, tmo;

  // In IDLE the aligner looks at the incoming request (store lanes, misalign);
  // afterwards it looks at the latched request (load extension).
  assign al_op  = (state_q == IDLE) ? bus.in_op : ctl_q.op;
  assign al_off = (state_q == IDLE) ? bus.in_addr[1:0] : ctl_q.off;

  ysyx_23060042_lsu_align u_align (
    .op_i      (al_op),
    .off_i     (al_off),
    .wdata_i   (bus.in_wdata),
    .rdata_i   (bus.mem_rdata),
    .wstrb_o   (al_wstrb),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata),
    .misalign_o(al_mis)
  );

  assign is_mem = bus.in_ren | bus.in_wen;
  assign cnt_d  = cnt_q + 1'b1;
  // Compare with >= : a grant on the last allowed cycle lands in RESP with
  // the budget already spent, and only a same-cycle rvalid can still win.
  assign tmo    = (cnt_q >= CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctl_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          in_ready_q <= 1'b0;
          if (is_mem && !al_mis) begin
            ctl_q   <= '{we: bus.in_wen, op: bus.in_op, off: bus.in_addr[1:0]};
            waddr_q <= bus.in_addr[ADDR_W-1:2];
            wdata_q <= al_wdata;
            wstrb_q <= bus.in_wen ? al_wstrb : 4'b0000;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= REQ;
          end else begin
            // non-memory op or rejected misaligned access
            rdata_q     <= '0;
            err_q       <= is_mem;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            req_q   <= 1'b0;
            cnt_q   <= cnt_d;
            state_q <= RESP;
          end else if (tmo) begin
            req_q       <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (bus.mem_rvalid) begin
            rdata_q     <= ctl_q.we ? '0 : al_rdata;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (tmo) begin
            rdata_q     <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_rdata = rdata_q;
  assign bus.out_err   = err_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = ctl_q.we;
  assign bus.mem_addr  = {waddr_q, 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_ysyx_23060042_lsu.sv
module tb_ysyx_23060042_lsu;
  import ysyx_23060042_lsu_pkg::*;

  logic clk, rst_n;
  ysyx_23060042_lsu_if #(.ADDR_W(32), .DATA_W(32)) lif();

  ysyx_23060042_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(255)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (lif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        ren, wen;
    logic [31:0] addr, wdata, mrd;
    logic        bus;      // expect a bus access
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_rdata;
    logic        e_err;
    int          e_lat;    // negedges from accept to out_valid
    int          gdly;     // cycles mem_gnt held low
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic [2:0] op, logic ren, logic wen,
                              logic [31:0] addr, logic [31:0] wd, logic [31:0] mrd,
                              logic bus, logic [31:0] ea, logic [3:0] es, logic [31:0] ew,
                              logic [31:0] er, logic ee, int lat, int gdly);
    vec_t v;
    v.name = nm; v.op = op; v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wd;
    v.mrd = mrd; v.bus = bus; v.e_addr = ea; v.e_strb = es; v.e_wdata = ew;
    v.e_rdata = er; v.e_err = ee; v.e_lat = lat; v.gdly = gdly;
    return v;
  endfunction

  task automatic idle_inputs();
    lif.in_valid = 0; lif.in_ren = 0; lif.in_wen = 0; lif.in_op = 3'b000;
    lif.in_addr = '0; lif.in_wdata = '0; lif.out_ready = 0;
    lif.mem_gnt = 0; lif.mem_rvalid = 0; lif.mem_rdata = '0;
  endtask

  // Present one request in IDLE; returns at the negedge right after acceptance.
  task automatic start(input logic [2:0] op, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    lif.in_valid = 1; lif.in_op = op; lif.in_ren = ren; lif.in_wen = wen;
    lif.in_addr = addr; lif.in_wdata = wd;
    @(negedge clk);
    lif.in_valid = 0; lif.in_ren = 0; lif.in_wen = 0;
  endtask

  task automatic finish_out(input string nm);
    lif.out_ready = 1;
    @(negedge clk);
    lif.out_ready = 0;
    chk($sformatf("%s.valid_clr", nm), lif.out_valid, 0);
    chk($sformatf("%s.ready_back", nm), lif.in_ready, 1);
  endtask

  task automatic do_txn(input vec_t v);
    int cyc, n;
    @(negedge clk);
    chk($sformatf("%s.in_ready", v.name), lif.in_ready, 1);
    start(v.op, v.ren, v.wen, v.addr, v.wdata);
    cyc = 1;
    if (v.bus) begin
      n = 0;
      while (!lif.mem_req && n < 10) begin @(negedge clk); n++; cyc++; end
      chk($sformatf("%s.req", v.name), lif.mem_req, 1);
      chk($sformatf("%s.addr", v.name), lif.mem_addr, v.e_addr);
      chk($sformatf("%s.we", v.name), lif.mem_we, v.wen);
      chk($sformatf("%s.wstrb", v.name), lif.mem_wstrb, v.e_strb);
      if (v.wen) chk($sformatf("%s.wdata", v.name), lif.mem_wdata, v.e_wdata);
      for (int i = 0; i < v.gdly; i++) begin
        @(negedge clk); cyc++;
        chk($sformatf("%s.req_hold", v.name), lif.mem_req, 1);
        chk($sformatf("%s.addr_hold", v.name), lif.mem_addr, v.e_addr);
      end
      lif.mem_gnt = 1;
      @(negedge clk); cyc++;
      lif.mem_gnt = 0;
      chk($sformatf("%s.req_drop", v.name), lif.mem_req, 0);
      lif.mem_rvalid = 1; lif.mem_rdata = v.mrd;
      @(negedge clk); cyc++;
      lif.mem_rvalid = 0;
    end else begin
      chk($sformatf("%s.no_req", v.name), lif.mem_req, 0);
    end
    n = 0;
    while (!lif.out_valid && n < 20) begin @(negedge clk); n++; cyc++; end
    chk($sformatf("%s.out_valid", v.name), lif.out_valid, 1);
    chk($sformatf("%s.latency", v.name), cyc, v.e_lat);
    chk($sformatf("%s.rdata", v.name), lif.out_rdata, v.e_rdata);
    chk($sformatf("%s.err", v.name), lif.out_err, v.e_err);
    chk($sformatf("%s.busy", v.name), lif.in_ready, 0);
    finish_out(v.name);
  endtask

  initial begin
    int n;
    idle_inputs();
    rst_n = 0;

    tbl.push_back(mk("lb_neg",  LSU_B,  1,0, 32'h8000_0003, 0, 32'h80FF_0000, 1, 32'h8000_0000, 4'b0000, 0, 32'hFFFF_FF80, 0, 3, 0));
    tbl.push_back(mk("lbu",     LSU_BU, 1,0, 32'h8000_0001, 0, 32'h1234_9A78, 1, 32'h8000_0000, 4'b0000, 0, 32'h0000_009A, 0, 3, 0));
    tbl.push_back(mk("lbu0",    LSU_BU, 1,0, 32'h8000_0000, 0, 32'h1234_56FF, 1, 32'h8000_0000, 4'b0000, 0, 32'h0000_00FF, 0, 3, 0));
    tbl.push_back(mk("lh_neg",  LSU_H,  1,0, 32'h8000_0002, 0, 32'h8765_4321, 1, 32'h8000_0000, 4'b0000, 0, 32'hFFFF_8765, 0, 3, 0));
    tbl.push_back(mk("lh_pos",  LSU_H,  1,0, 32'h8000_0000, 0, 32'h0000_7FFF, 1, 32'h8000_0000, 4'b0000, 0, 32'h0000_7FFF, 0, 3, 0));
    tbl.push_back(mk("lhu",     LSU_HU, 1,0, 32'h8000_0000, 0, 32'h1234_F00D, 1, 32'h8000_0000, 4'b0000, 0, 32'h0000_F00D, 0, 3, 0));
    tbl.push_back(mk("lw",      LSU_W,  1,0, 32'h8000_0004, 0, 32'hDEAD_BEEF, 1, 32'h8000_0004, 4'b0000, 0, 32'hDEAD_BEEF, 0, 3, 0));
    tbl.push_back(mk("lw_undef",3'b011, 1,0, 32'h8000_000C, 0, 32'h0BAD_CAFE, 1, 32'h8000_000C, 4'b0000, 0, 32'h0BAD_CAFE, 0, 3, 0));
    tbl.push_back(mk("sb",      LSU_B,  0,1, 32'h8000_0002, 32'h0000_00A5, 32'h1111_1111, 1, 32'h8000_0000, 4'b0100, 32'hA5A5_A5A5, 0, 0, 3, 0));
    tbl.push_back(mk("sb3",     LSU_B,  0,1, 32'h8000_0007, 32'h0000_003C, 32'h2222_2222, 1, 32'h8000_0004, 4'b1000, 32'h3C3C_3C3C, 0, 0, 3, 0));
    tbl.push_back(mk("sh",      LSU_H,  0,1, 32'h8000_0002, 32'h1234_ABCD, 32'h3333_3333, 1, 32'h8000_0000, 4'b1100, 32'hABCD_ABCD, 0, 0, 3, 0));
    tbl.push_back(mk("sw_slow", LSU_W,  0,1, 32'h8000_0008, 32'hCAFE_F00D, 32'h4444_4444, 1, 32'h8000_0008, 4'b1111, 32'hCAFE_F00D, 0, 0, 5, 2));
    tbl.push_back(mk("nop",     LSU_W,  0,0, 32'h8000_0003, 32'h5555_5555, 0, 0, 0, 0, 0, 0, 0, 1, 0));
`ifdef LSU_MISALIGN_CHK_EN
    tbl.push_back(mk("lw_mis",  LSU_W,  1,0, 32'h8000_0001, 0, 32'hA1B2_C3D4, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk("lh_odd",  LSU_H,  1,0, 32'h8000_0003, 0, 32'h8001_0002, 0, 0, 0, 0, 0, 1, 1, 0));
`else
    tbl.push_back(mk("lw_mis",  LSU_W,  1,0, 32'h8000_0001, 0, 32'hA1B2_C3D4, 1, 32'h8000_0000, 4'b0000, 0, 32'hA1B2_C3D4, 0, 3, 0));
    tbl.push_back(mk("lh_odd",  LSU_H,  1,0, 32'h8000_0003, 0, 32'h8001_0002, 1, 32'h8000_0000, 4'b0000, 0, 32'hFFFF_8001, 0, 3, 0));
`endif

    // reset state
    repeat (2) @(negedge clk);
    chk("rst.in_ready", lif.in_ready, 1);
    chk("rst.out_valid", lif.out_valid, 0);
    chk("rst.mem_req", lif.mem_req, 0);
    chk("rst.out_rdata", lif.out_rdata, 0);
    chk("rst.out_err", lif.out_err, 0);
    chk("rst.mem_wstrb", lif.mem_wstrb, 0);
    chk("rst.mem_we", lif.mem_we, 0);
    rst_n = 1;

    foreach (tbl[i]) do_txn(tbl[i]);

    // gnt never arrives: abort after exactly 255 REQ cycles
    start(LSU_W, 1, 0, 32'h8000_0010, 0);
    n = 0;
    while (lif.mem_req && !lif.out_valid && n < 400) begin n++; @(negedge clk); end
    chk("tmo.req_cycles", n, 255);
    chk("tmo.out_valid", lif.out_valid, 1);
    chk("tmo.err", lif.out_err, 1);
    chk("tmo.rdata", lif.out_rdata, 0);
    chk("tmo.req_low", lif.mem_req, 0);
    finish_out("tmo");

    // gnt on the last allowed cycle and rvalid right after: bus events win
    start(LSU_W, 1, 0, 32'h8000_0014, 0);
    repeat (254) @(negedge clk);
    chk("late.req", lif.mem_req, 1);
    lif.mem_gnt = 1;
    @(negedge clk);
    lif.mem_gnt = 0;
    chk("late.no_tmo", lif.out_valid, 0);
    lif.mem_rvalid = 1; lif.mem_rdata = 32'h5A5A_1234;
    @(negedge clk);
    lif.mem_rvalid = 0;
    chk("late.out_valid", lif.out_valid, 1);
    chk("late.err", lif.out_err, 0);
    chk("late.rdata", lif.out_rdata, 32'h5A5A_1234);
    finish_out("late");

    // WBU stalls 5 cycles in DONE while EXU keeps offering work
    start(LSU_B, 1, 0, 32'h8000_0003, 0);
    lif.mem_gnt = 1;
    @(negedge clk);
    lif.mem_gnt = 0; lif.mem_rvalid = 1; lif.mem_rdata = 32'h80FF_0000;
    @(negedge clk);
    lif.mem_rvalid = 0; lif.mem_rdata = 32'h0000_0000;
    lif.in_valid = 1; lif.in_op = LSU_W; lif.in_ren = 1; lif.in_addr = 32'h8000_0040;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d.valid", i), lif.out_valid, 1);
      chk($sformatf("stall%0d.rdata", i), lif.out_rdata, 32'hFFFF_FF80);
      chk($sformatf("stall%0d.in_ready", i), lif.in_ready, 0);
      chk($sformatf("stall%0d.no_req", i), lif.mem_req, 0);
      @(negedge clk);
    end
    lif.in_valid = 0; lif.in_ren = 0;
    finish_out("stall");
    chk("stall.no_new_req", lif.mem_req, 0);

    // async reset while in REQ: mem_req drops without waiting for a clock
    start(LSU_W, 1, 0, 32'h8000_0020, 0);
    chk("rstreq.req_before", lif.mem_req, 1);
    rst_n = 0;
    #1;
    chk("rstreq.req", lif.mem_req, 0);
    chk("rstreq.in_ready", lif.in_ready, 1);
    @(negedge clk);
    rst_n = 1;

    // async reset while in RESP
    start(LSU_W, 1, 0, 32'h8000_0024, 0);
    lif.mem_gnt = 1;
    @(negedge clk);
    lif.mem_gnt = 0;
    rst_n = 0;
    #1;
    chk("rstresp.req", lif.mem_req, 0);
    chk("rstresp.out_valid", lif.out_valid, 0);
    chk("rstresp.in_ready", lif.in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    do_txn(mk("lhu_after_rst", LSU_HU, 1,0, 32'h8000_0000, 0, 32'hFFFF_8001, 1, 32'h8000_0000, 4'b0000, 0, 32'h0000_8001, 0, 3, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
